// File: rtl/hex_digest_loader.sv
// Shifts ASCII hex characters into a NIBBLES-wide digest, first character ending up in the top nibble; one char per cycle.
// Accepts only while loading (CharReady registered from state); stops on completion or on a non-hex char until the next Start.
module hex_digest_loader #(
    parameter int NIBBLES = 64
) (
    input  logic                 Clk,
    input  logic                 Reset,
    input  logic                 Start,
    input  logic [7:0]           CharIn,
    input  logic                 CharValid,
    output logic                 CharReady,
    output logic [4*NIBBLES-1:0] DigestOut,
    output logic                 DigestValid,
    output logic                 CharError,
    output logic [6:0]           NibbleCount
);

    typedef enum logic [1:0] {
        IDLE,
        LOAD,
        DONE,
        ERR
    } state_t;

    state_t     state;
    logic [3:0] nib;
    logic       nib_ok;
    logic       last_nib;

    always_comb begin
        nib    = 4'd0;
        nib_ok = 1'b0;
        if (CharIn >= 8'h30 && CharIn <= 8'h39) begin
            nib    = 4'(CharIn - 8'h30);
            nib_ok = 1'b1;
        end else if (CharIn >= 8'h61 && CharIn <= 8'h66) begin
            nib    = 4'(CharIn - 8'h57);
            nib_ok = 1'b1;
        end else if (CharIn >= 8'h41 && CharIn <= 8'h46) begin
            nib    = 4'(CharIn - 8'h37);
            nib_ok = 1'b1;
        end
    end

    assign last_nib = (NibbleCount == 7'(NIBBLES - 1));

    // Start overrides any coincident handshake; Reset overrides both.
    always_ff @(posedge Clk) begin
        if (Reset) begin
            state       <= IDLE;
            DigestOut   <= '0;
            NibbleCount <= 7'd0;
            CharReady   <= 1'b0;
            DigestValid <= 1'b0;
            CharError   <= 1'b0;
        end else if (Start) begin
            state       <= LOAD;
            DigestOut   <= '0;
            NibbleCount <= 7'd0;
            CharReady   <= 1'b1;
            DigestValid <= 1'b0;
            CharError   <= 1'b0;
        end else begin
            case (state)
                LOAD: begin
                    if (CharValid) begin
                        if (nib_ok) begin
                            DigestOut   <= {DigestOut[4*NIBBLES-5:0], nib};
                            NibbleCount <= NibbleCount + 7'd1;
                            if (last_nib) begin
                                state       <= DONE;
                                CharReady   <= 1'b0;
                                DigestValid <= 1'b1;
                            end
                        end else begin
                            state     <= ERR;
                            CharReady <= 1'b0;
                            CharError <= 1'b1;
                        end
                    end
                end
                default: begin
                    state <= state;
                end
            endcase
        end
    end

endmodule

// File: tb/tb_hex_digest_loader.sv
// Randomized bench for hex_digest_loader: a string-level reference model predicts completion/error events and snapshots.
module tb_hex_digest_loader;
    localparam int N = 64;
    localparam int W = 4 * N;

    logic         Clk = 1'b0;
    logic         Reset;
    logic         Start;
    logic [7:0]   CharIn;
    logic         CharValid;
    logic         CharReady;
    logic [W-1:0] DigestOut;
    logic         DigestValid;
    logic         CharError;
    logic [6:0]   NibbleCount;

    always #5 Clk = ~Clk;

    hex_digest_loader #(.NIBBLES(N)) dut (
        .Clk        (Clk),
        .Reset      (Reset),
        .Start      (Start),
        .CharIn     (CharIn),
        .CharValid  (CharValid),
        .CharReady  (CharReady),
        .DigestOut  (DigestOut),
        .DigestValid(DigestValid),
        .CharError  (CharError),
        .NibbleCount(NibbleCount)
    );

    typedef struct {
        logic         rdy;
        logic         vld;
        logic         err;
        logic [6:0]   cnt;
        logic [W-1:0] dig;
    } exp_t;

    exp_t  sbq[$];
    int    tests = 0;
    int    fails = 0;
    int    snap_issued = 0;
    int    snap_done = 0;
    string hexstr = "0123456789abcdef";
    string badstr = "gG/:@`z ";

    // Reference model state: digest as a number built from accepted characters
    logic [W-1:0] m_dig;
    int           m_cnt;
    bit           m_load, m_done, m_err;

    function automatic int hex_val(logic [7:0] c);
        logic [7:0] lc;
        lc = (c >= "A" && c <= "Z") ? c + 8'h20 : c;
        for (int i = 0; i < 16; i++)
            if (lc == hexstr[i]) return i;
        return -1;
    endfunction

    task automatic push_exp();
        exp_t e;
        e.rdy = m_load;
        e.vld = m_done;
        e.err = m_err;
        e.cnt = 7'(m_cnt);
        e.dig = m_dig;
        sbq.push_back(e);
    endtask

    task automatic model_accept(logic [7:0] c);
        int v;
        if (!m_load) return;
        v = hex_val(c);
        if (v < 0) begin
            m_err  = 1'b1;
            m_load = 1'b0;
            push_exp();
        end else begin
            m_dig = m_dig * W'(16) + W'(v);
            m_cnt++;
            if (m_cnt == N) begin
                m_done = 1'b1;
                m_load = 1'b0;
                push_exp();
            end
        end
    endtask

    task automatic chk(string nm, logic [W-1:0] act, logic [W-1:0] exp);
        tests++;
        if (act !== exp) begin
            fails++;
            $display("FAIL %s: got %h expected %h", nm, act, exp);
        end
    endtask

    task automatic pop_check(string nm);
        exp_t e;
        if (sbq.size() == 0) begin
            tests++;
            fails++;
            $display("FAIL %s: unexpected event, got vld=%0b err=%0b cnt=%0d expected none",
                     nm, DigestValid, CharError, NibbleCount);
        end else begin
            e = sbq.pop_front();
            chk({nm, ".CharReady"},   W'(CharReady),   W'(e.rdy));
            chk({nm, ".DigestValid"}, W'(DigestValid), W'(e.vld));
            chk({nm, ".CharError"},   W'(CharError),   W'(e.err));
            chk({nm, ".NibbleCount"}, W'(NibbleCount), W'(e.cnt));
            chk({nm, ".DigestOut"},   DigestOut,       e.dig);
        end
    endtask

    // Monitor: samples 1 time unit after each falling edge
    initial begin
        logic pv, pe;
        repeat (2) @(negedge Clk);
        #1;
        pv = DigestValid;
        pe = CharError;
        forever begin
            @(negedge Clk);
            #1;
            if (DigestValid && !pv) pop_check("done");
            if (CharError && !pe)   pop_check("err");
            if (snap_done != snap_issued) begin
                pop_check("snap");
                snap_done++;
            end
            pv = DigestValid;
            pe = CharError;
        end
    end

    task automatic drive(logic v, logic [7:0] c);
        @(negedge Clk);
        Reset     = 1'b0;
        Start     = 1'b0;
        CharValid = v;
        CharIn    = c;
        if (v) model_accept(c);
    endtask

    task automatic idle_cycles(int n);
        repeat (n) drive(1'b0, 8'($urandom_range(255)));
    endtask

    task automatic send_str(string s, int gap_pct);
        logic [7:0] c;
        for (int i = 0; i < s.len(); i++) begin
            if (gap_pct > 0 && $urandom_range(99) < gap_pct)
                idle_cycles($urandom_range(1, 3));
            c = s[i];
            drive(1'b1, c);
        end
    endtask

    task automatic do_start(logic v, logic [7:0] c);
        @(negedge Clk);
        Reset     = 1'b0;
        Start     = 1'b1;
        CharValid = v;
        CharIn    = c;
        m_dig  = '0;
        m_cnt  = 0;
        m_load = 1'b1;
        m_done = 1'b0;
        m_err  = 1'b0;
    endtask

    task automatic do_reset();
        @(negedge Clk);
        Reset     = 1'b1;
        Start     = 1'b1;
        CharValid = 1'b1;
        CharIn    = "5";
        m_dig  = '0;
        m_cnt  = 0;
        m_load = 1'b0;
        m_done = 1'b0;
        m_err  = 1'b0;
    endtask

    task automatic snap();
        @(negedge Clk);
        Reset     = 1'b0;
        Start     = 1'b0;
        CharValid = 1'b0;
        push_exp();
        snap_issued++;
    endtask

    function automatic string rand_hex(int n, int bad_pct);
        string s;
        string one;
        logic [7:0] c;
        s = "";
        for (int i = 0; i < n; i++) begin
            if ($urandom_range(99) < bad_pct) begin
                c = badstr[$urandom_range(7)];
            end else begin
                c = hexstr[$urandom_range(15)];
                if (c >= "a" && $urandom_range(1) == 1) c = c - 8'h20;
            end
            one = " ";
            one[0] = c;
            s = {s, one};
        end
        return s;
    endfunction

    initial begin
        string s;
        Reset = 1'b1; Start = 1'b0; CharValid = 1'b0; CharIn = 8'h00;
        m_dig = '0; m_cnt = 0; m_load = 1'b0; m_done = 1'b0; m_err = 1'b0;
        repeat (2) @(posedge Clk);
        snap();

        // IDLE ignores characters
        send_str("abc", 0);
        snap();

        // Full load with CharValid held, then extra chars ignored in DONE
        do_start(1'b0, 8'h00);
        snap();
        s = "";
        repeat (4) s = {s, "0123456789abcdef"};
        send_str(s, 0);
        send_str("0123", 0);
        snap();

        // Error path, further chars ignored
        do_start(1'b0, 8'h00);
        send_str("ABCDEF0123", 0);
        drive(1'b1, "g");
        send_str("456", 0);
        snap();

        // Gappy CharValid, all 'f'
        do_start(1'b0, 8'h00);
        s = "";
        repeat (N) s = {s, "f"};
        send_str(s, 50);
        snap();

        // Start coincident with a handshake drops the char
        do_start(1'b0, 8'h00);
        send_str(rand_hex(30, 0), 20);
        do_start(1'b1, "7");
        snap();
        send_str(rand_hex(N, 0), 20);
        snap();

        // Restart from DONE with all '0'
        do_start(1'b0, 8'h00);
        snap();
        s = "";
        repeat (N) s = {s, "0"};
        send_str(s, 10);
        snap();

        // Reset mid-load (with Start asserted) returns to IDLE
        do_start(1'b0, 8'h00);
        send_str(rand_hex(20, 0), 0);
        do_reset();
        snap();
        send_str("123", 0);
        snap();

        // Random loads, some with invalid characters or too short
        for (int r = 0; r < 8; r++) begin
            do_start(1'b0, 8'h00);
            send_str(rand_hex($urandom_range(10, 70), 3), $urandom_range(0, 60));
            snap();
        end

        for (int i = 0; i < 20 && (sbq.size() != 0 || snap_done != snap_issued); i++)
            @(negedge Clk);
        @(negedge Clk);
        #2;
        tests++;
        if (sbq.size() != 0 || snap_done != snap_issued) begin
            fails++;
            $display("FAIL drain: %0d expectations left, required 0", sbq.size());
        end
        $display("[TB] %0d tests run, %0d failed", tests, fails);
        $finish;
    end

    initial begin
        #1000000;
        $display("FAIL watchdog: time limit reached with %0d expectations pending, required 0", sbq.size());
        $fatal(1, "watchdog");
    end

endmodule
